seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter that produces the bitstream consumed by the team's serial sequence detectors (e.g. the 1101 detector). A host loads a pattern word, a length and a repeat count through a valid/ready handshake. The block then shifts the pattern out MSB-first, one bit per clock, on a single-bit output with a qualifying valid. It is used as on-chip stimulus for detector blocks and as a simple serial framer.

Parameters:
W, 16, maximum pattern width in bits (2..32)
LEN_W, 5, width of len port; must satisfy 2^LEN_W > W
CNT_W, 8, width of repeat-count port

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
load_valid  input  1  host presents a pattern load
load_ready  output  1  block can accept a load (high only in IDLE/DONE)
pattern  input  W  bits to send; bit [len-1] is sent first
len  input  LEN_W  number of bits per repetition; 0 or >W means W
repeat  input  CNT_W  extra repetitions; total sends = repeat+1
out  output  1  serial data bit
out_valid  output  1  out carries a pattern (or marker) bit this cycle
busy  output  1  high while in SEND or MARK
done  output  1  one-cycle pulse after the final bit of a load

Behaviour:
- One clock, synchronous active-high reset. Reset values: out=0, out_valid=0, busy=0, done=0, load_ready=1, FSM=IDLE. Reset asserted mid-frame aborts the frame: no done pulse, outputs at reset values after the edge.
- FSM states:
  - IDLE: load_ready=1. On accept (load_valid & load_ready at posedge), latch pattern, effective len L and repeat count R, then go to SEND.
  - SEND: out=shift_reg MSB, out_valid=1, busy=1. Bit counter counts L bits. After bit L: if R>0, decrement R, reload shift_reg from the latched pattern, and continue in SEND with no gap. Otherwise go to MARK (feature enabled) or DONE.
  - MARK: see Optional Feature.
  - DONE: lasts one cycle. done=1, out_valid=0, out=0, load_ready=1. An accept in this cycle goes to SEND; otherwise go to IDLE.
- Latency: the first bit appears in the cycle immediately after the accept edge. Back-to-back loads leave exactly one non-valid cycle (the DONE cycle) between frames.
- Input sampling: pattern, len and repeat are sampled only on accept. Later changes have no effect. load_valid while busy is ignored; no queuing.
- Length rules:
  - len=1 sends pattern[0] only.
  - len=0 or len>W gives L=W.
  - Bits of pattern above L-1 are ignored.
- Counts: R and the bit counter are unsigned. Repeat=2^CNT_W-1 is legal and sends 2^CNT_W repetitions with no overflow.
- When out_valid=0, out is forced to 0.

Optional Feature:
SEQ_TX_MARKER_EN
- Defined: after each repetition's last pattern bit, the FSM enters MARK and emits the fixed 4-bit marker 1,1,0,1 with out_valid=1. Marker bits count toward busy. The next repetition, or DONE, follows the marker. Frame length = (R+1)*(L+4) valid bits.
- Undefined: MARK state and marker logic are absent; SEND goes directly to the next repetition or to DONE.

Test Plan:
- Reset, then load pattern=16'h000D, len=4, repeat=0 -> out=1,1,0,1 with out_valid=1 on cycles 1-4 after accept; done=1 on cycle 5; load_ready=1 on cycle 5.
- Load pattern=16'h000D, len=4, repeat=2 -> 12 consecutive valid bits 1101 1101 1101 with no gaps; single done pulse on cycle 13; a 1101 detector driven by out asserts 3 times.
- Load pattern=16'hA5A5, len=0 -> 16 bits 1010 0101 1010 0101; done on cycle 17. Repeat with len=20 -> identical output.
- Hold load_valid=1 with two different patterns (4'hB len 4, then 4'h6 len 3) -> 1,0,1,1, one cycle with out_valid=0 and done=1, then 1,1,0.
- Assert rst for one cycle at bit 3 of a 16-bit frame -> next cycle out=0, out_valid=0, busy=0, load_ready=1; no done pulse.
- With SEQ_TX_MARKER_EN, load pattern=2'b10, len=2, repeat=1 -> 1,0,1,1,0,1,1,0,1,1,0,1 (12 valid bits); done on cycle 13. Without the macro -> 1,0,1,0; done on cycle 5.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a loaded pattern out MSB-first with optional repeats.
// Optional marker insertion after each repetition is enabled with `define SEQ_TX_MARKER_EN.
// The repeat-count port is named repeat_cnt because "repeat" is a reserved SystemVerilog keyword.
module seq_pattern_tx #(
    parameter int W     = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [W-1:0]     pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] W_L = LEN_W'(W);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
`ifdef SEQ_TX_MARKER_EN
        , MARK
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     shift_reg, pat_reg, pat_aligned;
    logic [LEN_W-1:0] len_reg, bit_cnt, eff_len;
    logic [CNT_W-1:0] rpt_reg;
    logic             load, reload, shift;

`ifdef SEQ_TX_MARKER_EN
    localparam logic [3:0] MARKER = 4'b1101;
    logic [1:0] mark_cnt;
`endif

    // Left-align the pattern so the first bit to send always sits in the MSB.
    always_comb begin
        eff_len     = (len == '0 || len > W_L) ? W_L : len;
        pat_aligned = pattern << (W_L - eff_len);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output and control strobe gets a default first so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        out        = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        reload     = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out       = shift_reg[W-1];
                out_valid = 1'b1;
                busy      = 1'b1;
                if (bit_cnt == '0) begin
`ifdef SEQ_TX_MARKER_EN
                    state_nxt = MARK;
`else
                    if (rpt_reg != '0) reload = 1'b1;
                    else               state_nxt = DONE;
`endif
                end else begin
                    shift = 1'b1;
                end
            end
`ifdef SEQ_TX_MARKER_EN
            MARK: begin
                out       = MARKER[~mark_cnt];
                out_valid = 1'b1;
                busy      = 1'b1;
                if (mark_cnt == 2'd3) begin
                    if (rpt_reg != '0) begin
                        reload    = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
`endif
            DONE: begin
                done       = 1'b1;
                load_ready = 1'b1;
                if (load_valid) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: datapath registers carry no reset; outputs are qualified by the FSM state alone.
    always_ff @(posedge clk) begin
        if (load) begin
            pat_reg   <= pat_aligned;
            shift_reg <= pat_aligned;
            len_reg   <= eff_len;
            bit_cnt   <= eff_len - LEN_W'(1);
            rpt_reg   <= repeat_cnt;
        end else if (reload) begin
            shift_reg <= pat_reg;
            bit_cnt   <= len_reg - LEN_W'(1);
            rpt_reg   <= rpt_reg - CNT_W'(1);
        end else if (shift) begin
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt - LEN_W'(1);
        end
    end

`ifdef SEQ_TX_MARKER_EN
    always_ff @(posedge clk) begin
        if (state == MARK) mark_cnt <= mark_cnt + 2'd1;
        else               mark_cnt <= 2'd0;
    end
`endif

endmodule
